// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around a 1-bit full-adder
// cell. Operands are accepted through a start/ready handshake and added LSB
// first, one bit per clock, with a registered carry. The result is committed
// together with a one-cycle done pulse.
// Optional build macro: SERIAL_ADDER_OVF_EN adds ovf_out, the two's-complement
// signed overflow of the committed result.

module serial_adder_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum_c,
  output logic carry_c
);

  // Combinational 1-bit full adder: parity sum and majority carry.
  always_comb begin
    sum_c   = a ^ b ^ ci;
    carry_c = (a & b) | (a & ci) | (b & ci);
  end

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             ready_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state;
  state_e           state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] a_sr_nx;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] b_sr_nx;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_sr_nx;
  logic             carry;
  logic             carry_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  logic             ready_nx;
  logic             busy_nx;
  logic             done_nx;
  logic [WIDTH-1:0] sum_nx;
  logic             c_nx;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_nx;
`endif

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   s_cat;

  serial_adder_fa_cell u_fa (
    .a       (a_sr[0]),
    .b       (b_sr[0]),
    .ci      (carry),
    .sum_c   (fa_s),
    .carry_c (fa_co)
  );

  // New sum bit enters at the MSB; the upper WIDTH bits are the shifted result.
  assign s_cat = {fa_s, s_sr};

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_nx = state;
    a_sr_nx  = a_sr;
    b_sr_nx  = b_sr;
    s_sr_nx  = s_sr;
    carry_nx = carry;
    cnt_nx   = cnt;
    sum_nx   = sum_out;
    c_nx     = c_out;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_nx   = ovf_out;
`endif

    case (state)
      IDLE: begin
        if (start_in) begin
          a_sr_nx  = a_in;
          b_sr_nx  = b_in;
          carry_nx = c_in;
          cnt_nx   = '0;
          s_sr_nx  = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        a_sr_nx  = a_sr >> 1;
        b_sr_nx  = b_sr >> 1;
        s_sr_nx  = s_cat[WIDTH:1];
        carry_nx = fa_co;
        cnt_nx   = cnt + CNT_W'(1);
        if (cnt == LAST_BIT) begin
          sum_nx   = s_cat[WIDTH:1];
          c_nx     = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // Carry into the MSB is the carry held during the last bit.
          ovf_nx   = carry ^ fa_co;
`endif
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    ready_nx = (state_nx == IDLE);
    busy_nx  = (state_nx == RUN);
    done_nx  = (state_nx == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      ready_out <= 1'b1;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      c_out     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      a_sr      <= a_sr_nx;
      b_sr      <= b_sr_nx;
      s_sr      <= s_sr_nx;
      carry     <= carry_nx;
      cnt       <= cnt_nx;
      ready_out <= ready_nx;
      busy_out  <= busy_nx;
      done_out  <= done_nx;
      sum_out   <= sum_nx;
      c_out     <= c_nx;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_out   <= ovf_nx;
`endif
    end
  end

endmodule
